bp_table_arbiter: RTL and testbench
===================================

# bp_table_arbiter

Sequencer and port arbiter for the 256-entry, 2-bit saturating-counter branch predictor table, held in a single-port RAM. Fetch-stage lookups and ROB-commit counter updates share that one port. Each cycle the block grants the port to exactly one requester. ROB updates are buffered in a small FIFO and applied as read-modify-write (RMW) sequences. After reset, a sweep clears the whole table.

## Interface
- TAG_W, 8: predictor index width; table has 2**TAG_W entries
- UPD_DEPTH, 4: update FIFO depth, power of two, ≥2
- STARVE_LIM, 8: cycles a pending update may lose arbitration before it gets forced priority

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state holds and no port access occurs
- in_fetch_valid  in  1  lookup request
- in_fetch_tag  in  TAG_W  lookup index
- out_fetch_ready  out  1  lookup accepted this cycle
- out_fetch_res_valid  out  1  registered result valid
- out_fetch_res  out  1  predicted taken (counter bit 1)
- in_rob_valid  in  1  update push
- in_rob_tag  in  TAG_W  update index
- in_rob_taken  in  1  resolved direction
- out_rob_full  out  1  FIFO cannot accept a push
- out_busy  out  1  init sweep or update in progress

## Operation
- Reset values: out_fetch_ready=0, out_fetch_res_valid=0, out_fetch_res=0, out_rob_full=1, out_busy=1. FIFO is emptied, the update FSM goes to INIT, the sweep index is 0 and the starve counter is 0.
- INIT: writes 2'b00 to entry idx every rdy cycle and increments idx. After writing entry 2**TAG_W-1, goes to IDLE. During INIT, out_fetch_ready=0 and out_rob_full=1.
- Update FSM: IDLE → RD → WR → IDLE.
  - IDLE: FIFO non-empty → RD.
  - RD: when the port is granted to the update, read the head entry; next state is WR.
  - WR: when granted, write the new value and pop the head. Next state is RD if the FIFO is still non-empty, otherwise IDLE.
- New counter value: on taken, counter+1 saturating at 3. On not-taken, counter−1 saturating at 0. Arithmetic is 2-bit only; the counter never wraps.
- Arbitration when the FSM is in RD or WR:
  - Fetch wins if in_fetch_valid=1 and starve counter < STARVE_LIM and FIFO not full.
  - Otherwise the update wins and out_fetch_ready=0.
- Starve counter: increments each cycle the update loses arbitration. Clears on every update grant.
- out_fetch_ready is combinational: 1 when not in INIT, not rdy-frozen, and fetch wins or no update is pending.
- Push handling: out_rob_full = (count==UPD_DEPTH) or INIT.
  - A push while full is dropped, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
- Fetch reads of a tag with queued but unapplied updates return the stale value, except as stated under Configuration.
- rst asserted mid-RMW or mid-sweep: the in-flight update is discarded and the sweep restarts at index 0.

## Timing
- Lookup: accepted in cycle N; out_fetch_res_valid=1 and out_fetch_res valid in N+1 for one cycle.
- Update, uncontended: pushed N, read N+1, written N+2. A back-to-back update issues its RD at N+3.
- Two same-tag updates are serialized, so the second one reads the first one's written value.
- Init sweep: 2**TAG_W rdy cycles after rst deasserts.

## Configuration
- BP_ARB_BYPASS_EN defined: a lookup granted while the FSM is in WR, with in_fetch_tag equal to the WR entry's tag, returns bit 1 of the pending new value in N+1.
- Undefined: that lookup returns the pre-update RAM contents.

## Structure
- Shared package: TAG_W default, counter width (2), the SAT_MAX/SAT_MIN constants, and the FSM state encoding (INIT, IDLE, RD, WR).
- One sub-module: bp_table_ram, a 2**TAG_W × 2 single-port synchronous RAM (one read or write per cycle, 1-cycle read latency).

## Test plan
- Reset, then 256 cycles: out_busy=1 and out_rob_full=1 throughout; then a lookup of tag 0x5A → out_fetch_res=0.
- Three pushes of tag 0x10 taken, then a lookup → out_fetch_res=1 (counter=3). A fourth taken push → counter stays 3.
- Counter 0 at tag 0x20, push not-taken → counter stays 0 and the next lookup returns 0.
- Continuous fetch requests with one pending update → fetch is denied on the 9th contested cycle and the update completes.
- Fill FIFO to 4 entries, then push a 5th → dropped. Fetch stalls until count < 4.
- Lookup of the tag in WR (1→2): returns 1 with BP_ARB_BYPASS_EN defined, 0 without it.

Source files
------------

// File: rtl/bp_table_arbiter_pkg.sv
// Shared types and constants for the branch-predictor table arbiter:
// counter width, saturation bounds, update FSM encoding and the counter step.
package bp_table_arbiter_pkg;

    localparam int TAG_W_DEF = 8;
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] SAT_MAX = 2'd3;
    localparam logic [CNT_W-1:0] SAT_MIN = 2'd0;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } upd_state_e;

    // Saturating 2-bit step: never wraps past SAT_MAX or below SAT_MIN.
    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt, input logic taken);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != SAT_MAX) res = cnt + CNT_W'(1);
        end else begin
            if (cnt != SAT_MIN) res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_table_arbiter_if.sv
// Fetch-lookup and ROB-update handshake bundle between the pipeline (master)
// and the predictor table arbiter (slave).
interface bp_table_arbiter_if
    import bp_table_arbiter_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
);
    logic             in_fetch_valid;
    logic [TAG_W-1:0] in_fetch_tag;
    logic             out_fetch_ready;
    logic             out_fetch_res_valid;
    logic             out_fetch_res;
    logic             in_rob_valid;
    logic [TAG_W-1:0] in_rob_tag;
    logic             in_rob_taken;
    logic             out_rob_full;
    logic             out_busy;

    modport master (
        output in_fetch_valid, in_fetch_tag, in_rob_valid, in_rob_tag, in_rob_taken,
        input  out_fetch_ready, out_fetch_res_valid, out_fetch_res, out_rob_full, out_busy
    );

    modport slave (
        input  in_fetch_valid, in_fetch_tag, in_rob_valid, in_rob_tag, in_rob_taken,
        output out_fetch_ready, out_fetch_res_valid, out_fetch_res, out_rob_full, out_busy
    );
endinterface

// File: rtl/bp_table_arbiter_ram.sv
// bp_table_ram: single-port 2**TAG_W x 2 counter table, one read or write
// per enabled cycle, read data registered (1-cycle latency, holds when idle).
module bp_table_ram
    import bp_table_arbiter_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [TAG_W-1:0] i_addr,
    input  logic [CNT_W-1:0] i_wdata,
    output logic [CNT_W-1:0] o_rdata
);
    logic [CNT_W-1:0] r_mem [0:(1<<TAG_W)-1];
    logic [CNT_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) r_mem[i_addr] <= i_wdata;
            else      r_rdata       <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/bp_table_arbiter.sv
// Port arbiter/sequencer for the predictor table: init sweep, fetch lookups and
// buffered read-modify-write updates. Optional BP_ARB_BYPASS_EN forwards WR data.
module bp_table_arbiter
    import bp_table_arbiter_pkg::*;
#(
    parameter int TAG_W      = TAG_W_DEF,
    parameter int UPD_DEPTH  = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    bp_table_arbiter_if.slave bus
);
    localparam int PTR_W   = $clog2(UPD_DEPTH);
    localparam int CNT_Q_W = PTR_W + 1;
    localparam int STV_W   = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_Q_W-1:0] DEPTH_C  = CNT_Q_W'(UPD_DEPTH);
    localparam logic [STV_W-1:0]   STARVE_C = STV_W'(STARVE_LIM);
    localparam logic [TAG_W-1:0]   IDX_LAST = '1;

    upd_state_e r_state, w_state_next;
    logic [TAG_W-1:0]     r_idx;
    logic [TAG_W-1:0]     r_fifo_tag [UPD_DEPTH];
    logic [UPD_DEPTH-1:0] r_fifo_taken;
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_Q_W-1:0]   r_count;
    logic [STV_W-1:0]     r_starve;
    logic                 r_rd_pending;
    logic [CNT_W-1:0]     r_new_val;
    logic                 r_res_valid;

    logic             w_full, w_upd_pending, w_fetch_wins, w_fetch_ready;
    logic             w_fetch_grant, w_upd_grant, w_push, w_pop;
    logic [CNT_Q_W-1:0] w_count_next;
    logic [TAG_W-1:0] w_head_tag;
    logic             w_head_taken;
    logic [CNT_W-1:0] w_rdata, w_new_val;
    logic             w_ram_en, w_ram_we;
    logic [TAG_W-1:0] w_ram_addr;
    logic [CNT_W-1:0] w_ram_wdata;

    assign w_full        = (r_count == DEPTH_C) || (r_state == INIT);
    assign w_upd_pending = (r_state == RD) || (r_state == WR);
    assign w_fetch_wins  = bus.in_fetch_valid && (r_starve < STARVE_C) && (r_count != DEPTH_C);
    assign w_fetch_ready = rdy && (r_state != INIT) && (w_fetch_wins || !w_upd_pending);
    assign w_fetch_grant = w_fetch_ready && bus.in_fetch_valid;
    assign w_upd_grant   = rdy && w_upd_pending && !w_fetch_wins;
    assign w_push        = rdy && bus.in_rob_valid && !w_full;
    assign w_pop         = w_upd_grant && (r_state == WR);
    assign w_count_next  = r_count + CNT_Q_W'(w_push) - CNT_Q_W'(w_pop);
    assign w_head_tag    = r_fifo_tag[r_rd_ptr];
    assign w_head_taken  = r_fifo_taken[r_rd_ptr];

    // RAM output is only trustworthy in the first WR cycle; after that a
    // fetch may have overwritten it, so the computed value is held in r_new_val.
    assign w_new_val = r_rd_pending ? sat_update(w_rdata, w_head_taken) : r_new_val;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT: if (r_idx == IDX_LAST) w_state_next = IDLE;
            IDLE: if ((r_count != '0) || w_push) w_state_next = RD;
            RD:   if (w_upd_grant) w_state_next = WR;
            WR:   if (w_upd_grant) w_state_next = (w_count_next != '0) ? RD : IDLE;
            default: w_state_next = INIT;
        endcase
    end

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = bus.in_fetch_tag;
        w_ram_wdata = SAT_MIN;
        if (r_state == INIT) begin
            w_ram_en   = rdy;
            w_ram_we   = 1'b1;
            w_ram_addr = r_idx;
        end else if (w_fetch_grant) begin
            w_ram_en = 1'b1;
        end else if (w_upd_grant) begin
            w_ram_en    = 1'b1;
            w_ram_we    = (r_state == WR);
            w_ram_addr  = w_head_tag;
            w_ram_wdata = w_new_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_idx   <= '0;
        end else if (rdy) begin
            r_state <= w_state_next;
            if (r_state == INIT) r_idx <= r_idx + TAG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            r_rd_pending <= 1'b0;
            r_res_valid  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            if (rdy) begin
                r_rd_pending <= w_upd_grant && (r_state == RD);
                r_res_valid  <= w_fetch_grant;
                if (w_upd_grant)        r_starve <= '0;
                else if (w_upd_pending) r_starve <= r_starve + STV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_tag[r_wr_ptr]   <= bus.in_rob_tag;
            r_fifo_taken[r_wr_ptr] <= bus.in_rob_taken;
        end
        if (rdy && r_rd_pending) r_new_val <= w_new_val;
    end

    bp_table_ram #(.TAG_W(TAG_W)) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rdata)
    );

`ifdef BP_ARB_BYPASS_EN
    logic r_byp_hit, r_byp_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_hit <= 1'b0;
            r_byp_bit <= 1'b0;
        end else if (w_fetch_grant) begin
            r_byp_hit <= (r_state == WR) && (bus.in_fetch_tag == w_head_tag);
            r_byp_bit <= w_new_val[1];
        end
    end

    assign bus.out_fetch_res = r_res_valid && (r_byp_hit ? r_byp_bit : w_rdata[1]);
`else
    assign bus.out_fetch_res = r_res_valid && w_rdata[1];
`endif

    assign bus.out_fetch_ready     = w_fetch_ready;
    assign bus.out_fetch_res_valid = r_res_valid;
    assign bus.out_rob_full        = w_full;
    assign bus.out_busy            = (r_state != IDLE);
endmodule

// File: tb/tb_bp_table_arbiter.sv
// Scoreboard bench for bp_table_arbiter: directed scenarios plus random traffic
// checked against a counter-table model with a list of not-yet-confirmed updates.
module tb_bp_table_arbiter;
    import bp_table_arbiter_pkg::*;

    localparam int TW = 8;
`ifdef BP_ARB_BYPASS_EN
    localparam int BYP_EXP = 1;
`else
    localparam int BYP_EXP = 0;
`endif

    typedef struct { int tag; bit taken; } upd_t;
    typedef struct { int cyc; bit known; bit val; int tag; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   model [1<<TW];
    upd_t pend [$];
    exp_t sbq [$];

    bp_table_arbiter_if #(.TAG_W(TW)) bus ();

    bp_table_arbiter #(.TAG_W(TW), .UPD_DEPTH(4), .STARVE_LIM(8)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int v, input bit t);
        if (t) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush_pend();
        foreach (pend[i]) model[pend[i].tag] = sat(model[pend[i].tag], pend[i].taken);
        pend.delete();
    endtask

    // Result is determinate only if every prefix of the queued updates agrees on bit 1.
    task automatic record_lookup(input int tag, input int force_exp);
        exp_t e;
        int   v;
        bit   b0;
        bit   same;
        e.cyc = cyc;
        e.tag = tag;
        if (force_exp >= 0) begin
            e.known = 1'b1;
            e.val   = force_exp[0];
        end else begin
            v    = model[tag];
            b0   = (v >= 2);
            same = 1'b1;
            foreach (pend[i]) begin
                if (pend[i].tag == tag) begin
                    v = sat(v, pend[i].taken);
                    if ((v >= 2) != b0) same = 1'b0;
                end
            end
            e.known = same;
            e.val   = b0;
        end
        sbq.push_back(e);
    endtask

    task automatic step(input bit fv, input int ftag, input bit rv, input int rtag, input bit rtk,
                        input int force_exp, output bit f_acc, output bit r_acc);
        @(posedge clk);
        #1;
        bus.in_fetch_valid = fv;
        bus.in_fetch_tag   = TW'(ftag);
        bus.in_rob_valid   = rv;
        bus.in_rob_tag     = TW'(rtag);
        bus.in_rob_taken   = rtk;
        @(negedge clk);
        if (!rst && !bus.out_busy) flush_pend();
        f_acc = fv && bus.out_fetch_ready;
        r_acc = rv && !bus.out_rob_full;
        if (f_acc) record_lookup(ftag, force_exp);
        if (r_acc) pend.push_back('{rtag, rtk});
    endtask

    task automatic idle(output bit busy);
        bit fa, ra;
        step(1'b0, 0, 1'b0, 0, 1'b0, -1, fa, ra);
        busy = bus.out_busy;
    endtask

    task automatic wait_idle(output int n);
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 300) begin
            idle(busy);
            n++;
        end
        chk("drain_timeout", int'(busy), 0);
    endtask

    task automatic lookup(input int tag, input int force_exp, input string name);
        bit fa, ra, busy;
        step(1'b1, tag, 1'b0, 0, 1'b0, force_exp, fa, ra);
        chk(name, int'(fa), 1);
        idle(busy);
    endtask

    task automatic push(input int tag, input bit tk, input string name);
        bit fa, ra;
        step(1'b0, 0, 1'b1, tag, tk, -1, fa, ra);
        chk(name, int'(ra), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_fetch_valid = 1'b1;
        bus.in_fetch_tag   = '0;
        bus.in_rob_valid   = 1'b1;
        bus.in_rob_tag     = '0;
        bus.in_rob_taken   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fetch_ready", int'(bus.out_fetch_ready), 0);
        chk("rst_res_valid", int'(bus.out_fetch_res_valid), 0);
        chk("rst_res", int'(bus.out_fetch_res), 0);
        chk("rst_rob_full", int'(bus.out_rob_full), 1);
        chk("rst_busy", int'(bus.out_busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        foreach (model[i]) model[i] = 0;
        pend.delete();
        for (int i = 0; i < (1 << TW); i++) begin
            @(negedge clk);
            chk("init_busy_full_noready",
                int'({bus.out_busy, bus.out_rob_full, bus.out_fetch_ready}), 3'b110);
        end
        bus.in_fetch_valid = 1'b0;
        bus.in_rob_valid   = 1'b0;
        @(negedge clk);
        chk("init_done", int'(bus.out_busy), 0);
    endtask

    // Monitor: every presented result must match the oldest accepted lookup.
    always @(negedge clk) begin
        if (!rst && bus.out_fetch_res_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_res_unexpected: got result %0d with no lookup outstanding (cycle %0d)",
                         bus.out_fetch_res, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("fetch_res_latency", cyc - e.cyc, 1);
                if (e.known) begin
                    checks++;
                    if (bus.out_fetch_res !== e.val) begin
                        errors++;
                        $display("FAIL fetch_res tag=0x%02h: got %0d, expected %0d (cycle %0d)",
                                 e.tag, bus.out_fetch_res, e.val, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit fa, ra, busy;
        int n, deny;
        bus.in_fetch_valid = 1'b0;
        bus.in_fetch_tag   = '0;
        bus.in_rob_valid   = 1'b0;
        bus.in_rob_tag     = '0;
        bus.in_rob_taken   = 1'b0;

        do_reset();
        lookup('h5A, 0, "init_lookup_5a_acc");

        // Three taken updates back to back, then check the RMW pipeline spacing.
        push('h10, 1'b1, "push_10_a");
        push('h10, 1'b1, "push_10_b");
        push('h10, 1'b1, "push_10_c");
        wait_idle(n);
        chk("b2b_drain_cycles", n, 5);
        lookup('h10, 1, "lookup_10_sat3_acc");
        push('h10, 1'b1, "push_10_d");
        idle(busy); chk("upd_rd_busy", int'(busy), 1);
        idle(busy); chk("upd_wr_busy", int'(busy), 1);
        idle(busy); chk("upd_done_idle", int'(busy), 0);
        lookup('h10, 1, "lookup_10_stays3_acc");

        push('h20, 1'b0, "push_20_nt");
        wait_idle(n);
        lookup('h20, 0, "lookup_20_stays0_acc");

        // Starvation: one pending update against continuous fetches.
        push('h50, 1'b1, "push_50");
        deny = 0;
        for (int k = 1; k <= 18; k++) begin
            step(1'b1, 'h51, 1'b0, 0, 1'b0, -1, fa, ra);
            chk($sformatf("starve_ready_k%0d", k), int'(fa), int'((k % 9) != 0));
            if (!fa) deny++;
        end
        idle(busy);
        chk("starve_update_done", int'(busy), 0);
        chk("starve_denials", deny, 2);
        lookup('h50, 0, "lookup_50_acc");

        // FIFO fill: fifth push while full is dropped; fetch stalls until a pop.
        push('h40, 1'b1, "push_40_pre");
        wait_idle(n);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 'h70, 1'b1, 'h60 + k, 1'b1, -1, fa, ra);
            chk($sformatf("fill_push_acc_%0d", k), int'(ra), 1);
            chk($sformatf("fill_fetch_acc_%0d", k), int'(fa), 1);
        end
        step(1'b1, 'h70, 1'b1, 'h40, 1'b1, -1, fa, ra);
        chk("full_push_dropped", int'(ra), 0);
        chk("full_fetch_stall", int'(fa), 0);
        step(1'b1, 'h70, 1'b0, 0, 1'b0, -1, fa, ra);
        chk("full_wr_fetch_stall", int'(fa), 0);
        step(1'b1, 'h70, 1'b0, 0, 1'b0, -1, fa, ra);
        chk("after_pop_fetch_acc", int'(fa), 1);
        wait_idle(n);
        lookup('h40, 0, "lookup_40_drop_acc");
        lookup('h63, 0, "lookup_63_acc");

        // Lookup of the entry currently in WR (counter 1 -> 2).
        push('h30, 1'b1, "push_30_pre");
        wait_idle(n);
        push('h30, 1'b1, "push_30_wr");
        idle(busy);
        step(1'b1, 'h30, 1'b0, 0, 1'b0, BYP_EXP, fa, ra);
        chk("wr_lookup_acc", int'(fa), 1);
        wait_idle(n);
        lookup('h30, 1, "lookup_30_after_acc");

        // Random traffic on a small tag set so updates and lookups collide.
        for (int i = 0; i < 2000; i++) begin
            if ((i % 100) >= 80) begin
                step(1'b0, 0, 1'b0, 0, 1'b0, -1, fa, ra);
            end else begin
                step(1'($urandom_range(0, 1)), 'h80 + int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 9) < 4), 'h80 + int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), -1, fa, ra);
            end
        end
        wait_idle(n);
        for (int t = 'h80; t < 'h88; t++) lookup(t, -1, "rand_final_lookup_acc");

        // Reset in the middle of an RMW: table and queued update are discarded.
        push('h11, 1'b1, "push_11_pre_rst");
        idle(busy);
        do_reset();
        lookup('h10, 0, "post_rst_10_acc");
        lookup('h11, 0, "post_rst_11_acc");

        idle(busy);
        idle(busy);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
